piece_fall_ctrl: RTL and testbench



---
 rtl/piece_fall_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_piece_fall_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_fall_ctrl.sv
// Falling-piece controller for the 8x4 board: spawn, gravity, player moves, lock and GEN/CLEAR sequencing.
// Optional hard drop (btn_drop) is compiled in when HARD_DROP_EN is defined.
module piece_fall_ctrl #(
    parameter int GRAV_CYCLES = 50,
    parameter int CLR_LAT     = 2
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic [31:0] board_in,
    input  logic        error_in,
    input  logic [1:0]  curr_piece,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_down,
`ifdef HARD_DROP_EN
    input  logic        btn_drop,
`endif
    output logic [31:0] board_out,
    output logic [2:0]  state,
    output logic        game_over
);

    typedef enum logic [2:0] {
        ST_GEN   = 3'd0,
        ST_FALL  = 3'd1,
        ST_LOCK  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4,
        ST_LOAD  = 3'd5
    } state_e;

    localparam int GW = (GRAV_CYCLES > 1) ? $clog2(GRAV_CYCLES) : 1;
    localparam int WW = (CLR_LAT > 1) ? $clog2(CLR_LAT) : 1;
    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(CLR_LAT - 1);
    localparam logic [31:0]   COL0_MASK = 32'h1111_1111;
    localparam logic [31:0]   COL3_MASK = 32'h8888_8888;

    state_e      state_q, state_d;
    logic [31:0] settled_q, settled_d;
    logic [31:0] piece_q, piece_d;
    logic [31:0] board_q, board_d;
    logic [GW-1:0] grav_q, grav_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        left_q, right_q, down_q;

    logic        left_edge, right_edge, down_edge;
    logic [31:0] spawn_mask;
    logic [31:0] piece_dn, piece_lt, piece_rt;
    logic        down_ok, left_ok, right_ok;
    logic        down_req, drop_active;

    assign left_edge  = btn_left  & ~left_q;
    assign right_edge = btn_right & ~right_q;
    assign down_edge  = btn_down  & ~down_q;

    assign piece_dn = piece_q << 4;
    assign piece_lt = piece_q >> 1;
    assign piece_rt = piece_q << 1;
    assign down_ok  = (piece_q[31:28] == 4'h0) && ((piece_dn & settled_q) == 32'h0);
    assign left_ok  = ((piece_q & COL0_MASK) == 32'h0) && ((piece_lt & settled_q) == 32'h0);
    assign right_ok = ((piece_q & COL3_MASK) == 32'h0) && ((piece_rt & settled_q) == 32'h0);

    always_comb begin
        case (curr_piece)
            2'd0:    spawn_mask = 32'h0000_0002;
            2'd1:    spawn_mask = 32'h0000_0006;
            2'd2:    spawn_mask = 32'h0000_0066;
            default: spawn_mask = 32'h0000_0062;
        endcase
    end

`ifdef HARD_DROP_EN
    logic drop_btn_q, drop_q, drop_d, drop_edge;
    assign drop_edge   = btn_drop & ~drop_btn_q;
    assign drop_active = drop_q | drop_edge;
`else
    assign drop_active = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        settled_d = settled_q;
        piece_d   = piece_q;
        grav_d    = grav_q;
        wait_d    = wait_q;
        down_req  = 1'b0;
`ifdef HARD_DROP_EN
        drop_d    = drop_q;
`endif
        case (state_q)
            ST_GEN: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_LOAD: begin
                if (error_in) begin
                    state_d = ST_OVER;
                end else begin
                    piece_d   = spawn_mask;
                    settled_d = board_in & ~spawn_mask;
                    grav_d    = '0;
                    state_d   = ST_FALL;
                end
            end
            ST_FALL: begin
`ifdef HARD_DROP_EN
                drop_d = drop_active;
`endif
                // Hard drop freezes the gravity counter and swallows lateral requests.
                if (drop_active) begin
                    down_req = 1'b1;
                end else if ((grav_q == GRAV_LAST) || down_edge) begin
                    down_req = 1'b1;
                    grav_d   = '0;
                end else begin
                    grav_d = grav_q + GW'(1);
                end

                if (down_req) begin
                    if (down_ok) begin
                        piece_d = piece_dn;
                    end else begin
                        state_d = ST_LOCK;
`ifdef HARD_DROP_EN
                        drop_d  = 1'b0;
`endif
                    end
                end else if (left_edge && !right_edge) begin
                    if (left_ok) piece_d = piece_lt;
                end else if (right_edge && !left_edge) begin
                    if (right_ok) piece_d = piece_rt;
                end
            end
            ST_LOCK: begin
                settled_d = settled_q | piece_q;
                piece_d   = '0;
                wait_d    = '0;
                state_d   = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (wait_q == WAIT_LAST) begin
                    settled_d = board_in;
                    wait_d    = '0;
                    state_d   = ST_GEN;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: begin
                state_d = ST_OVER;
            end
        endcase

        // board_out follows the state being entered; frozen once the game is over.
        if (state_q == ST_OVER) begin
            board_d = board_q;
        end else if (state_d == ST_FALL) begin
            board_d = settled_d | piece_d;
        end else begin
            board_d = settled_d;
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q   <= ST_GEN;
            settled_q <= '0;
            piece_q   <= '0;
            board_q   <= '0;
            grav_q    <= '0;
            wait_q    <= '0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settled_q <= settled_d;
            piece_q   <= piece_d;
            board_q   <= board_d;
            grav_q    <= grav_d;
            wait_q    <= wait_d;
            left_q    <= btn_left;
            right_q   <= btn_right;
            down_q    <= btn_down;
        end
    end

`ifdef HARD_DROP_EN
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            drop_btn_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_btn_q <= btn_drop;
            drop_q     <= drop_d;
        end
    end
`endif

    assign board_out = board_q;
    assign state     = state_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Directed bench for piece_fall_ctrl: spawn, lateral limits, gravity, lock/clear, game over, reset.
// The hard-drop section is active only when HARD_DROP_EN is defined.
module tb_piece_fall_ctrl;

    logic        clka = 1'b0;
    logic        restart_n = 1'b0;
    logic [31:0] board_in;
    logic        error_in = 1'b0;
    logic [1:0]  curr_piece = 2'd0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_down = 1'b0;
`ifdef HARD_DROP_EN
    logic        btn_drop = 1'b0;
`endif
    logic [31:0] board_out;
    logic [2:0]  state;
    logic        game_over;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    logic [31:0] gen_extra = 32'h0;
    logic [31:0] fall_tbl [6];

    always #5 clka = ~clka;

    function automatic logic [31:0] tb_mask(input logic [1:0] p);
        case (p)
            2'd0:    return 32'h0000_0002;
            2'd1:    return 32'h0000_0006;
            2'd2:    return 32'h0000_0066;
            default: return 32'h0000_0062;
        endcase
    endfunction

    // Downstream model: during GEN/LOAD it returns the board with the new piece drawn in
    // (plus any pre-seeded rubble); otherwise it echoes board_out with nothing cleared.
    always_comb begin
        board_in = board_out;
        if (state == 3'd0 || state == 3'd5) board_in = board_out | gen_extra | tb_mask(curr_piece);
    end

    piece_fall_ctrl dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .board_in   (board_in),
        .error_in   (error_in),
        .curr_piece (curr_piece),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
`ifdef HARD_DROP_EN
        .btn_drop   (btn_drop),
`endif
        .board_out  (board_out),
        .state      (state),
        .game_over  (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clka);
    endtask

    task automatic press(input logic l, input logic r, input logic d);
        btn_left = l; btn_right = r; btn_down = d;
        tick(1);
    endtask

    task automatic release_btns();
        btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
        tick(1);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, output int n);
        n = 0;
        while (state !== tgt && n < budget) begin
            @(negedge clka);
            n++;
        end
    endtask

    task automatic wait_change(input int budget, output int n);
        logic [31:0] prev;
        prev = board_out;
        n = 0;
        while (board_out === prev && n < budget) begin
            @(negedge clka);
            n++;
        end
    endtask

    initial begin
        fall_tbl[0] = 32'h0000_0660;
        fall_tbl[1] = 32'h0000_6600;
        fall_tbl[2] = 32'h0006_6000;
        fall_tbl[3] = 32'h0066_0000;
        fall_tbl[4] = 32'h0660_0000;
        fall_tbl[5] = 32'h6600_0000;

        // Reset values
        tick(2);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_board", board_out, 32'h0);
        check("rst_over", {31'd0, game_over}, 32'd0);

        // Square spawn: GEN two cycles, LOAD, FALL
        curr_piece = 2'd2;
        restart_n  = 1'b1;
        tick(1);
        check("gen_hold", {29'd0, state}, 32'd0);
        tick(1);
        check("load", {29'd0, state}, 32'd5);
        tick(1);
        check("fall_state", {29'd0, state}, 32'd1);
        check("spawn_sq", board_out, 32'h0000_0066);

        // Lateral moves and wall limits
        press(1'b0, 1'b1, 1'b0); check("right1", board_out, 32'h0000_00CC); release_btns();
        press(1'b0, 1'b1, 1'b0); check("right_wall", board_out, 32'h0000_00CC); release_btns();
        press(1'b1, 1'b0, 1'b0); check("left1", board_out, 32'h0000_0066); release_btns();
        press(1'b1, 1'b0, 1'b0); check("left2", board_out, 32'h0000_0033); release_btns();
        press(1'b1, 1'b0, 1'b0); check("left_wall", board_out, 32'h0000_0033); release_btns();
        press(1'b0, 1'b1, 1'b0); check("right_back", board_out, 32'h0000_0066); release_btns();
        press(1'b1, 1'b1, 1'b0); check("left_right", board_out, 32'h0000_0066); release_btns();

        // Gravity: six steps to the bottom row, period GRAV_CYCLES
        for (int k = 0; k < 6; k++) begin
            wait_change(60, cyc);
            check($sformatf("grav_step%0d", k + 1), board_out, fall_tbl[k]);
            if (k > 0) check($sformatf("grav_period%0d", k + 1), cyc, 32'd50);
        end
        wait_state(3'd2, 60, cyc);
        check("lock_state", {29'd0, state}, 32'd2);
        check("lock_period", cyc, 32'd50);
        check("lock_board", board_out, 32'h0);
        tick(1);
        check("clear_state", {29'd0, state}, 32'd3);
        check("clear_board", board_out, 32'h6600_0000);
        wait_state(3'd0, 10, cyc);
        check("clear_len", cyc, 32'd2);
        check("gen_after_clear", {29'd0, state}, 32'd0);
        check("settled_sq", board_out, 32'h6600_0000);

        // Mid-operation reset takes effect asynchronously
        restart_n = 1'b0;
        #1;
        check("async_rst_board", board_out, 32'h0);
        check("async_rst_state", {29'd0, state}, 32'd0);
        tick(1);

        // Single piece over rubble at row 2; down beats a same-cycle left
        curr_piece = 2'd0;
        gen_extra  = 32'h0000_0F00;
        restart_n  = 1'b1;
        tick(3);
        check("single_fall", {29'd0, state}, 32'd1);
        check("single_spawn", board_out, 32'h0000_0F02);
        gen_extra = 32'h0;
        press(1'b1, 1'b0, 1'b1);
        check("down_beats_left", board_out, 32'h0000_0F20);
        release_btns();
        wait_state(3'd2, 60, cyc);
        check("blocked_lock", {29'd0, state}, 32'd2);
        check("blocked_period", cyc, 32'd49);
        tick(1);
        check("blocked_clear", board_out, 32'h0000_0F20);
        wait_state(3'd0, 10, cyc);
        check("settled_single", board_out, 32'h0000_0F20);

        // Spawn collision -> OVER, buttons ignored, board frozen
        error_in = 1'b1;
        wait_state(3'd4, 10, cyc);
        check("over_state", {29'd0, state}, 32'd4);
        check("over_flag", {31'd0, game_over}, 32'd1);
        check("over_board", board_out, 32'h0000_0F20);
        for (int i = 0; i < 100; i++) begin
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_down  = 1'($urandom_range(0, 1));
`ifdef HARD_DROP_EN
            btn_drop  = 1'($urandom_range(0, 1));
`endif
            tick(1);
        end
        check("over_hold_state", {29'd0, state}, 32'd4);
        check("over_hold_board", board_out, 32'h0000_0F20);
        restart_n = 1'b0;
        #1;
        check("over_rst_board", board_out, 32'h0);
        check("over_rst_state", {29'd0, state}, 32'd0);
        check("over_rst_flag", {31'd0, game_over}, 32'd0);
        btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
        error_in = 1'b0;
        tick(1);

`ifdef HARD_DROP_EN
        btn_drop   = 1'b0;
        curr_piece = 2'd2;
        restart_n  = 1'b1;
        tick(3);
        check("drop_spawn", board_out, 32'h0000_0066);
        btn_drop = 1'b1;
        tick(1);
        btn_drop = 1'b0;
        check("drop_row1", board_out, fall_tbl[0]);
        for (int k = 1; k < 6; k++) begin
            tick(1);
            check($sformatf("drop_row%0d", k + 1), board_out, fall_tbl[k]);
        end
        tick(1);
        check("drop_lock", {29'd0, state}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
